// File: rtl/mc_control.sv
// Multicycle ARM-subset control unit: main FSM, ALU decoder, condition
// check with a registered condition result, and the {N,Z,C,V} flag register.
module mc_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUControl
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  // Condition-code evaluation against a {N,Z,C,V} flag vector; 1111 never executes.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic res;
    {n, z, c, v} = flags;
    case (cond)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = c;
      4'b0011: res = ~c;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = c & ~z;
      4'b1001: res = ~c | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [3:0]  flags_r, flags_nxt_s;
  logic        cond_ex_r;

  logic [1:0]  op_s;
  logic [5:0]  funct_s;
  logic [3:0]  cmd_s;
  logic [3:0]  cond_s;
  logic [3:0]  rd_s;

  logic        next_pc_s, branch_s, reg_w_s, mem_w_s, ir_write_s;
  logic        adr_src_s, alu_src_a_s, alu_op_s;
  logic [1:0]  alu_src_b_s, result_src_s, alu_control_s;
  logic        cmd_ok_s, cmd_addsub_s, flag_wr_s, pcs_s;

  assign op_s    = Instr[27:26];
  assign funct_s = Instr[25:20];
  assign cmd_s   = Instr[24:21];
  assign cond_s  = Instr[31:28];
  assign rd_s    = Instr[15:12];

  // State register; reset restarts execution at FETCH.
  always_ff @(posedge clk) begin
    if (!reset) state_r <= FETCH;
    else        state_r <= state_nxt_s;
  end

  // Next-state selection from the current state and the instruction fields.
  always_comb begin
    state_nxt_s = FETCH;
    case (state_r)
      FETCH:  state_nxt_s = DECODE;
      DECODE: begin
        case (op_s)
          2'b01: state_nxt_s = MEMADR;
          2'b00: begin
            if (funct_s[5]) state_nxt_s = EXECI;
            else            state_nxt_s = EXECR;
          end
          2'b10: state_nxt_s = BRANCH;
          default: state_nxt_s = FETCH;
        endcase
      end
      MEMADR: begin
        if (funct_s[0]) state_nxt_s = MEMRD;
        else            state_nxt_s = MEMWR;
      end
      MEMRD:  state_nxt_s = MEMWB;
      EXECR:  state_nxt_s = ALUWB;
      EXECI:  state_nxt_s = ALUWB;
      default: state_nxt_s = FETCH;
    endcase
  end

  // Data-processing command decode; unsupported commands behave as a NOP.
  always_comb begin
    cmd_ok_s      = 1'b1;
    cmd_addsub_s  = 1'b0;
    alu_control_s = 2'b00;
    case (cmd_s)
      4'b0100: cmd_addsub_s = 1'b1;
      4'b0010: begin
        cmd_addsub_s  = 1'b1;
        alu_control_s = 2'b01;
      end
      4'b0000: alu_control_s = 2'b10;
      4'b1100: alu_control_s = 2'b11;
      default: cmd_ok_s = 1'b0;
    endcase
  end

  // Per-state datapath controls (Moore outputs) before condition gating.
  always_comb begin
    next_pc_s    = 1'b0;
    branch_s     = 1'b0;
    reg_w_s      = 1'b0;
    mem_w_s      = 1'b0;
    ir_write_s   = 1'b0;
    adr_src_s    = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_op_s     = 1'b0;
    alu_src_b_s  = 2'b00;
    result_src_s = 2'b00;
    case (state_r)
      FETCH: begin
        ir_write_s   = 1'b1;
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        next_pc_s    = 1'b1;
      end
      DECODE: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
      end
      MEMADR: alu_src_b_s = 2'b01;
      MEMRD:  adr_src_s   = 1'b1;
      MEMWB: begin
        result_src_s = 2'b01;
        reg_w_s      = 1'b1;
      end
      MEMWR: begin
        adr_src_s = 1'b1;
        mem_w_s   = 1'b1;
      end
      EXECR:  alu_op_s = 1'b1;
      EXECI: begin
        alu_src_b_s = 2'b01;
        alu_op_s    = 1'b1;
      end
      ALUWB:  reg_w_s = cmd_ok_s;
      BRANCH: begin
        alu_src_b_s  = 2'b01;
        result_src_s = 2'b10;
        branch_s     = 1'b1;
      end
      default: begin
        next_pc_s = 1'b0;
      end
    endcase
  end

  // Flag update: N,Z for any supported S-instruction that executes, C,V only for ADD/SUB.
  always_comb begin
    flag_wr_s   = alu_op_s & funct_s[0] & cmd_ok_s & cond_ex_r;
    flags_nxt_s = flags_r;
    if (flag_wr_s) begin
      flags_nxt_s[3:2] = ALUFlags[3:2];
      if (cmd_addsub_s) flags_nxt_s[1:0] = ALUFlags[1:0];
      else              flags_nxt_s[1:0] = flags_r[1:0];
    end else begin
      flags_nxt_s = flags_r;
    end
  end

  // Flag register.
  always_ff @(posedge clk) begin
    if (!reset) flags_r <= 4'b0000;
    else        flags_r <= flags_nxt_s;
  end

  // Condition result captured as DECODE ends, held for the rest of the instruction.
  always_ff @(posedge clk) begin
    if (!reset)                 cond_ex_r <= 1'b0;
    else if (state_r == DECODE) cond_ex_r <= cond_check(cond_s, flags_r);
    else                        cond_ex_r <= cond_ex_r;
  end

  // Condition-gated enables; every output is held low while reset is asserted.
  always_comb begin
    pcs_s = branch_s | (reg_w_s & (rd_s == 4'd15));
    if (reset) begin
      PCWrite    = next_pc_s | (pcs_s & cond_ex_r);
      RegWrite   = reg_w_s & cond_ex_r;
      MemWrite   = mem_w_s & cond_ex_r;
      IRWrite    = ir_write_s;
      AdrSrc     = adr_src_s;
      ALUSrcA    = alu_src_a_s;
      RegSrc     = {(op_s == 2'b01), (op_s == 2'b10)};
      ImmSrc     = op_s;
      ALUSrcB    = alu_src_b_s;
      ResultSrc  = result_src_s;
      ALUControl = alu_op_s ? alu_control_s : 2'b00;
    end else begin
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      RegSrc     = 2'b00;
      ImmSrc     = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = 2'b00;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed, table-driven bench for mc_control: per-cycle vectors of
// {reset, Instr, ALUFlags, expected outputs}, plus instruction-latency sequences.
module tb_mc_control;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ResultSrc, ALUControl;

  mc_control dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .RegSrc(RegSrc), .ImmSrc(ImmSrc),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout:
  // {PCWrite,RegWrite,MemWrite,IRWrite}_{AdrSrc,ALUSrcA}_RegSrc_ImmSrc_ALUSrcB_ResultSrc_ALUControl
  logic [15:0] got;
  assign got = {PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA,
                RegSrc, ImmSrc, ALUSrcB, ResultSrc, ALUControl};

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic [3:0]  af;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] LDR   = 32'hE5912004;
  localparam logic [31:0] STR   = 32'hE5812000;
  localparam logic [31:0] SUBS  = 32'hE0510002;
  localparam logic [31:0] EORS  = 32'hE0310002;
  localparam logic [31:0] ADDS  = 32'hE0912003;
  localparam logic [31:0] ANDS  = 32'hE0112003;
  localparam logic [31:0] ADDEQ = 32'h00812003;
  localparam logic [31:0] ADDPC = 32'hE081F002;
  localparam logic [31:0] ORRI  = 32'hE3811001;
  localparam logic [31:0] BEQ   = 32'h0A000002;
  localparam logic [31:0] BCS   = 32'h2A000000;
  localparam logic [31:0] BVS   = 32'h6A000000;
  localparam logic [31:0] BAL   = 32'hEA000000;
  localparam logic [31:0] OP11  = 32'hEC000000;

  // Common FETCH/DECODE vectors per RegSrc/ImmSrc combination.
  localparam logic [15:0] F_DP  = 16'b1001_01_00_00_10_10_00;
  localparam logic [15:0] D_DP  = 16'b0000_01_00_00_10_10_00;
  localparam logic [15:0] F_MEM = 16'b1001_01_10_01_10_10_00;
  localparam logic [15:0] D_MEM = 16'b0000_01_10_01_10_10_00;
  localparam logic [15:0] F_BR  = 16'b1001_01_01_10_10_10_00;
  localparam logic [15:0] D_BR  = 16'b0000_01_01_10_10_10_00;
  localparam logic [15:0] ZERO  = 16'b0000_00_00_00_00_00_00;

  task automatic add(input logic rst, input logic [31:0] ins, input logic [3:0] af,
                     input logic [15:0] exp, input string nm);
    vec_t v;
    v.rst = rst; v.instr = ins; v.af = af; v.exp = exp; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic measure(input logic [31:0] ins, input int exp_lat, input string nm);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    Instr = ins;
    ALUFlags = 4'b0000;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 10 && !done; k++) begin
      @(posedge clk); #1;
      n++;
      if (IRWrite) done = 1'b1;
    end
    checks++;
    if (!done || n != exp_lat) begin
      errors++;
      $display("FAIL latency_%s: got %0d cycles (returned=%0d), expected %0d", nm, n, done, exp_lat);
    end
  endtask

  initial begin
    reset = 1'b0;
    Instr = LDR;
    ALUFlags = 4'b0000;

    // Reset held two cycles, then LDR
    add(1'b0, LDR, 4'h0, ZERO, "reset0");
    add(1'b0, LDR, 4'h0, ZERO, "reset1");
    add(1'b1, LDR, 4'h0, F_MEM, "ldr_fetch");
    add(1'b1, LDR, 4'h0, D_MEM, "ldr_decode");
    add(1'b1, LDR, 4'h0, 16'b0000_00_10_01_01_00_00, "ldr_memadr");
    add(1'b1, LDR, 4'h0, 16'b0000_10_10_01_00_00_00, "ldr_memrd");
    add(1'b1, LDR, 4'h0, 16'b0100_00_10_01_00_01_00, "ldr_memwb");
    // SUBS sets Z
    add(1'b1, SUBS, 4'b0100, F_DP, "subs_fetch");
    add(1'b1, SUBS, 4'b0100, D_DP, "subs_decode");
    add(1'b1, SUBS, 4'b0100, 16'b0000_00_00_00_00_00_01, "subs_execr");
    add(1'b1, SUBS, 4'b0100, 16'b0100_00_00_00_00_00_00, "subs_aluwb");
    // BEQ taken (Z=1)
    add(1'b1, BEQ, 4'h0, F_BR, "beq1_fetch");
    add(1'b1, BEQ, 4'h0, D_BR, "beq1_decode");
    add(1'b1, BEQ, 4'h0, 16'b1000_00_01_10_01_10_00, "beq1_branch");
    // EORS unsupported: NOP, no writeback, flags untouched
    add(1'b1, EORS, 4'b0000, F_DP, "eors_fetch");
    add(1'b1, EORS, 4'b0000, D_DP, "eors_decode");
    add(1'b1, EORS, 4'b0000, ZERO, "eors_execr");
    add(1'b1, EORS, 4'b0000, ZERO, "eors_aluwb");
    // BEQ still taken: Z survived EORS
    add(1'b1, BEQ, 4'h0, F_BR, "beq2_fetch");
    add(1'b1, BEQ, 4'h0, D_BR, "beq2_decode");
    add(1'b1, BEQ, 4'h0, 16'b1000_00_01_10_01_10_00, "beq2_branch");
    // SUBS clears all flags
    add(1'b1, SUBS, 4'b0000, F_DP, "subs2_fetch");
    add(1'b1, SUBS, 4'b0000, D_DP, "subs2_decode");
    add(1'b1, SUBS, 4'b0000, 16'b0000_00_00_00_00_00_01, "subs2_execr");
    add(1'b1, SUBS, 4'b0000, 16'b0100_00_00_00_00_00_00, "subs2_aluwb");
    // BEQ not taken (Z=0)
    add(1'b1, BEQ, 4'h0, F_BR, "beq3_fetch");
    add(1'b1, BEQ, 4'h0, D_BR, "beq3_decode");
    add(1'b1, BEQ, 4'h0, 16'b0000_00_01_10_01_10_00, "beq3_branch");
    // ADDS sets C
    add(1'b1, ADDS, 4'b0010, F_DP, "adds_fetch");
    add(1'b1, ADDS, 4'b0010, D_DP, "adds_decode");
    add(1'b1, ADDS, 4'b0010, 16'b0000_00_00_00_00_00_00, "adds_execr");
    add(1'b1, ADDS, 4'b0010, 16'b0100_00_00_00_00_00_00, "adds_aluwb");
    // ANDS loads N,Z only; C,V must hold 1,0
    add(1'b1, ANDS, 4'b0001, F_DP, "ands_fetch");
    add(1'b1, ANDS, 4'b0001, D_DP, "ands_decode");
    add(1'b1, ANDS, 4'b0001, 16'b0000_00_00_00_00_00_10, "ands_execr");
    add(1'b1, ANDS, 4'b0001, 16'b0100_00_00_00_00_00_00, "ands_aluwb");
    add(1'b1, BCS, 4'h0, F_BR, "bcs_fetch");
    add(1'b1, BCS, 4'h0, D_BR, "bcs_decode");
    add(1'b1, BCS, 4'h0, 16'b1000_00_01_10_01_10_00, "bcs_branch");
    add(1'b1, BVS, 4'h0, F_BR, "bvs_fetch");
    add(1'b1, BVS, 4'h0, D_BR, "bvs_decode");
    add(1'b1, BVS, 4'h0, 16'b0000_00_01_10_01_10_00, "bvs_branch");
    // ADDEQ with Z=0: write-back suppressed
    add(1'b1, ADDEQ, 4'h0, F_DP, "addeq_fetch");
    add(1'b1, ADDEQ, 4'h0, D_DP, "addeq_decode");
    add(1'b1, ADDEQ, 4'h0, ZERO, "addeq_execr");
    add(1'b1, ADDEQ, 4'h0, ZERO, "addeq_aluwb");
    // ADD to R15
    add(1'b1, ADDPC, 4'h0, F_DP, "addpc_fetch");
    add(1'b1, ADDPC, 4'h0, D_DP, "addpc_decode");
    add(1'b1, ADDPC, 4'h0, ZERO, "addpc_execr");
    add(1'b1, ADDPC, 4'h0, 16'b1100_00_00_00_00_00_00, "addpc_aluwb");
    // ORR immediate via EXECI
    add(1'b1, ORRI, 4'h0, F_DP, "orri_fetch");
    add(1'b1, ORRI, 4'h0, D_DP, "orri_decode");
    add(1'b1, ORRI, 4'h0, 16'b0000_00_00_00_01_00_11, "orri_execi");
    add(1'b1, ORRI, 4'h0, 16'b0100_00_00_00_00_00_00, "orri_aluwb");
    // Op=11 goes straight back to FETCH
    add(1'b1, OP11, 4'h0, 16'b1001_01_00_11_10_10_00, "op11_fetch");
    add(1'b1, OP11, 4'h0, 16'b0000_01_00_11_10_10_00, "op11_decode");
    // STR normal
    add(1'b1, STR, 4'h0, F_MEM, "str_fetch");
    add(1'b1, STR, 4'h0, D_MEM, "str_decode");
    add(1'b1, STR, 4'h0, 16'b0000_00_10_01_01_00_00, "str_memadr");
    add(1'b1, STR, 4'h0, 16'b0010_10_10_01_00_00_00, "str_memwr");
    // STR aborted by reset in MEMWR, then full STR
    add(1'b1, STR, 4'h0, F_MEM, "stra_fetch");
    add(1'b1, STR, 4'h0, D_MEM, "stra_decode");
    add(1'b1, STR, 4'h0, 16'b0000_00_10_01_01_00_00, "stra_memadr");
    add(1'b0, STR, 4'h0, ZERO, "stra_reset_memwr");
    add(1'b1, STR, 4'h0, F_MEM, "strb_fetch");
    add(1'b1, STR, 4'h0, D_MEM, "strb_decode");
    add(1'b1, STR, 4'h0, 16'b0000_00_10_01_01_00_00, "strb_memadr");
    add(1'b1, STR, 4'h0, 16'b0010_10_10_01_00_00_00, "strb_memwr");
    // Reset cleared C: BCS not taken
    add(1'b1, BCS, 4'h0, F_BR, "bcs2_fetch");
    add(1'b1, BCS, 4'h0, D_BR, "bcs2_decode");
    add(1'b1, BCS, 4'h0, 16'b0000_00_01_10_01_10_00, "bcs2_branch");

    foreach (vecs[i]) begin
      reset    = vecs[i].rst;
      Instr    = vecs[i].instr;
      ALUFlags = vecs[i].af;
      @(negedge clk);
      checks++;
      if (got !== vecs[i].exp) begin
        errors++;
        $display("FAIL %s (vec %0d): got %b expected %b", vecs[i].name, i, got, vecs[i].exp);
      end
      @(posedge clk); #1;
    end

    // Cycle count from one FETCH to the next per instruction class
    measure(LDR,  5, "ldr");
    measure(STR,  4, "str");
    measure(SUBS, 4, "dp");
    measure(BAL,  3, "b");
    measure(OP11, 2, "op11");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 No parameters; all widths are fixed.
REQ-002 clk  in  1  rising-edge clock; sole clock domain.
REQ-003 reset  in  1  synchronous, active-low reset; reset==0 at a rising clk edge resets the block.
REQ-004 Instr  in  32  instruction register contents; fields used: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
REQ-005 ALUFlags  in  4  ALU flags {N,Z,C,V} of the current-cycle ALU result.
REQ-006 PCWrite, RegWrite, MemWrite, IRWrite  out  1 each  datapath write enables.
REQ-007 AdrSrc, ALUSrcA  out  1 each  address mux select (0=PC, 1=Result); SrcA select (0=A, 1=PC).
REQ-008 RegSrc, ImmSrc  out  2 each  RegSrc[0]=1 forces RA1=15; RegSrc[1]=1 selects RA2=Rd; ImmSrc=Op.
REQ-009 ALUSrcB, ResultSrc, ALUControl  out  2 each  SrcB 00=RD2reg/01=ExtImm/10=const 4; Result 00=ALUOut/01=Data/10=ALUResult; ALU 00=ADD/01=SUB/10=AND/11=ORR.

Function
REQ-010 Main FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
REQ-011 Transitions: FETCH->DECODE; DECODE->MEMADR (Op=01), EXECR (Op=00, I=0), EXECI (Op=00, I=1), BRANCH (Op=10), FETCH (Op=11); MEMADR->MEMRD (L=1) / MEMWR (L=0); MEMRD->MEMWB; EXECR/EXECI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
REQ-012 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, NextPC=1.
REQ-013 DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10; no write enable asserted.
REQ-014 MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00. MEMRD: AdrSrc=1, ResultSrc=00. MEMWB: ResultSrc=01, RegW=1. MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
REQ-015 EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1. EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. ALUWB: ResultSrc=00, RegW=1. BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=00, ResultSrc=10, Branch=1.
REQ-016 Any output not listed for a state is 0 in that state.
REQ-017 RegSrc and ImmSrc are combinational from Op in every state: RegSrc[0]=(Op==10), RegSrc[1]=(Op==01), ImmSrc=Op.
REQ-018 With ALUOp=1, cmd=Funct[4:1] maps 0100->ADD, 0010->SUB, 0000->AND, 1100->ORR; any other cmd gives ALUControl=00 and suppresses RegW in ALUWB and all flag writes (NOP).
REQ-019 Condition check on Cond and the flag register: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 -> 0.
REQ-020 CondExR register captures the condition-check result at the end of DECODE and holds it until the next DECODE.
REQ-021 PCS=Branch | (RegW & Rd==15); PCWrite=NextPC | (PCS & CondExR); RegWrite=RegW & CondExR; MemWrite=MemW & CondExR.
REQ-022 Flag register {N,Z,C,V}: in EXECR/EXECI with Funct[0]=1 (S), a supported cmd and CondExR=1, N,Z load from ALUFlags[3:2]; C,V load from ALUFlags[1:0] only for ADD/SUB; otherwise the flags hold.
REQ-023 Flags written in EXEC do not affect the instruction's own write-back, which is gated by CondExR.
REQ-024 Latency from FETCH entry to next FETCH: LDR 5, STR 4, data-processing 4, B 3, Op=11 2 cycles.

Reset
REQ-025 reset==0 at a clk edge: state=FETCH, flags=0000, CondExR=0.
REQ-026 While reset==0, PCWrite, RegWrite, MemWrite and IRWrite are forced 0 and all other outputs are 0.
REQ-027 Reset mid-instruction aborts the instruction; no write enable asserts in the reset cycle; execution restarts at FETCH on the first cycle with reset==1.

Verification
REQ-028 Reset held 2 cycles, then released -> cycle 1 FETCH: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10; cycle 2 DECODE: all enables 0.
REQ-029 Instr=0xE5912004 (LDR AL) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 only in MEMWB with ResultSrc=01; MemWrite never asserted.
REQ-030 Instr=0xE0510002 (SUBS) with ALUFlags=0100 in EXECR -> ALUControl=01; flags=0100 after EXECR; RegWrite=1 in ALUWB.
REQ-031 Flags Z=0, Instr=0x0A000002 (BEQ) -> BRANCH with PCWrite=0, back to FETCH after 3 cycles; with Z=1 -> PCWrite=1 in BRANCH.
REQ-032 Instr=0xE5812000 (STR) with reset driven 0 during MEMWR -> MemWrite=0 that cycle; state=FETCH next cycle.
REQ-033 Instr=0xE081F002 (ADD to R15) -> PCWrite=1 and RegWrite=1 in ALUWB with ResultSrc=00; Instr=0xE0310002 (EORS, unsupported) -> RegWrite=0 and flags unchanged.
